// File: rtl/v810_icache_pkg.sv
// Shared constants and types for the V810 instruction cache.
package v810_icache_pkg;

    localparam int unsigned ICACHE_IDX_BITS = 7;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill0,
        StFill1,
        StResp
    } icache_state_t;

endpackage

// File: rtl/v810_icache_if.sv
// EU fetch port and MAU instruction port bundled as one interface.
interface v810_icache_if;

    logic [31:0] ia;
    logic        ireq;
    logic [31:0] id;
    logic        iack;
    logic [31:0] mia;
    logic        mireq;
    logic [31:0] mid;
    logic        miack;

    // slave: the cache; master: the EU/MAU side driving it
    modport slave  (input ia, ireq, mid, miack, output id, iack, mia, mireq);
    modport master (output ia, ireq, mid, miack, input id, iack, mia, mireq);

endinterface

// File: rtl/v810_icache_array.sv
// Tag and data storage: synchronous read, single write port, no reset.
module v810_icache_array import v810_icache_pkg::*; #(
    parameter int unsigned IDX_BITS = ICACHE_IDX_BITS,
    parameter int unsigned TAG_BITS = 29 - IDX_BITS
) (
    input  logic                clk,
    input  logic                re,
    input  logic [IDX_BITS-1:0] raddr,
    output logic [TAG_BITS-1:0] rtag,
    output logic [63:0]         rdata,
    input  logic                we,
    input  logic [IDX_BITS-1:0] waddr,
    input  logic [TAG_BITS-1:0] wtag,
    input  logic [63:0]         wdata
);

    localparam int unsigned Lines = 1 << IDX_BITS;

    logic [TAG_BITS-1:0] tag_mem  [Lines];
    logic [63:0]         data_mem [Lines];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            data_mem[waddr] <= wdata;
        end
        if (re) begin
            rtag  <= tag_mem[raddr];
            rdata <= data_mem[raddr];
        end
    end

endmodule

// File: rtl/v810_icache.sv
// Direct-mapped 8-byte-line instruction cache with a transparent pass-through mode.
module v810_icache import v810_icache_pkg::*; #(
    parameter int unsigned IDX_BITS = ICACHE_IDX_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          en,
    input  logic          inv,
    v810_icache_if.slave  bus
);

    localparam int unsigned TagBits = 29 - IDX_BITS;
    localparam int unsigned Lines   = 1 << IDX_BITS;

    icache_state_t       state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic [31:0]         fill0_q, fill0_d, fill1_q, fill1_d;
    logic [31:0]         id_q, id_d, mia_q, mia_d;
    logic                iack_q, iack_d, mireq_q, mireq_d;
    logic                live_q, live_d;
    logic [Lines-1:0]    valid_q;
    logic                arr_re, arr_we, hit, bypass;
    logic [TagBits-1:0]  rtag;
    logic [63:0]         rdata;
    logic [IDX_BITS-1:0] idx;

    assign idx = addr_q[IDX_BITS+2:3];
    assign hit = valid_q[idx] && (rtag == addr_q[31:IDX_BITS+3]);

    v810_icache_array #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TagBits)
    ) u_array (
        .clk   (clk),
        .re    (arr_re && ce),
        .raddr (bus.ia[IDX_BITS+2:3]),
        .rtag  (rtag),
        .rdata (rdata),
        .we    (arr_we && ce),
        .waddr (idx),
        .wtag  (addr_q[31:IDX_BITS+3]),
        .wdata ({bus.mid, fill0_q})
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fill0_d = fill0_q;
        fill1_d = fill1_q;
        id_d    = id_q;
        iack_d  = 1'b0;
        mia_d   = mia_q;
        mireq_d = mireq_q;
        live_d  = live_q;
        arr_re  = 1'b0;
        arr_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                arr_re = 1'b1;
                // iack_q guard: never re-issue in the ack cycle itself
                if (en && bus.ireq && !iack_q) begin
                    addr_d  = bus.ia[31:2];
                    live_d  = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (!bus.ireq) begin
                    state_d = StIdle;
                end else if (hit) begin
                    iack_d  = 1'b1;
                    id_d    = addr_q[2] ? rdata[63:32] : rdata[31:0];
                    state_d = StIdle;
                end else begin
                    mireq_d = 1'b1;
                    mia_d   = {addr_q[31:3], 3'b000};
                    state_d = StFill0;
                end
            end
            StFill0: begin
                if (!bus.ireq) live_d = 1'b0;
                if (bus.miack) begin
                    fill0_d = bus.mid;
                    mireq_d = 1'b0;
                    mia_d   = mia_q + 32'd4;
                    state_d = StFill1;
                end
            end
            StFill1: begin
                if (!bus.ireq) live_d = 1'b0;
                // Request is re-raised one cycle after the first word's ack.
                if (mireq_q && bus.miack) begin
                    fill1_d = bus.mid;
                    mireq_d = 1'b0;
                    arr_we  = 1'b1;
                    state_d = StResp;
                end else begin
                    mireq_d = 1'b1;
                end
            end
            StResp: begin
                iack_d = live_q;
                if (live_q) id_d = addr_q[2] ? fill1_q : fill0_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            fill0_q <= '0;
            fill1_q <= '0;
            id_q    <= '0;
            iack_q  <= 1'b0;
            mia_q   <= '0;
            mireq_q <= 1'b0;
            live_q  <= 1'b0;
            valid_q <= '0;
        end else if (ce) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fill0_q <= fill0_d;
            fill1_q <= fill1_d;
            id_q    <= id_d;
            iack_q  <= iack_d;
            mia_q   <= mia_d;
            mireq_q <= mireq_d;
            live_q  <= live_d;
            if (inv) valid_q <= '0;
            else if (arr_we) valid_q[idx] <= 1'b1;
        end
    end

    assign bypass    = (state_q == StIdle) && !en;
    assign bus.mireq = bypass ? bus.ireq : mireq_q;
    assign bus.mia   = bypass ? {bus.ia[31:2], 2'b00} : mia_q;
    assign bus.id    = bypass ? bus.mid : id_q;
    assign bus.iack  = bypass ? bus.miack : iack_q;

endmodule

// File: tb/tb_v810_icache.sv
// Directed bench: EU fetch driver, 1-wait MAU model and an expected-data scoreboard.
module tb_v810_icache;
    import v810_icache_pkg::*;

    logic clk = 1'b0;
    logic rst, ce, en, inv;
    v810_icache_if bus ();

    v810_icache #(.IDX_BITS (ICACHE_IDX_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .en  (en),
        .inv (inv),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passes = 0, total = 0;
    int nack = 0, mcnt = 0, mireq_cyc = 0, iack_cyc = 0;
    bit inv_arm = 0;
    int inv_target = 0;
    logic [31:0] exp_q[$];
    logic [31:0] log_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // One clock: MAU model reacts at the falling edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(negedge clk);
        if (rst || bus.miack) begin
            bus.miack = 1'b0;
            mcnt = 0;
        end else if (bus.mireq) begin
            if (mcnt == 1) begin
                bus.miack = 1'b1;
                bus.mid   = mem_word(bus.mia);
                log_q.push_back(bus.mia);
                nack++;
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
        if (inv_arm) inv = bus.miack && (nack == inv_target);
        #1;
        if (bus.mireq) mireq_cyc++;
        if (bus.iack) iack_cyc++;
    endtask

    task automatic fetch(input logic [31:0] a, output int lat, output int nm);
        int base;
        bit got;
        base = nack;
        got  = 0;
        lat  = 0;
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        bus.ia   = a;
        bus.ireq = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            lat++;
            if (bus.iack) got = 1;
        end
        bus.ireq = 1'b0;
        check("ack_seen", {31'b0, got}, 32'd1);
        if (got) check("fetch_id", bus.id, exp_q.pop_front());
        else void'(exp_q.pop_front());
        cycle();
        check("iack_pulse", {31'b0, bus.iack}, 32'd0);
        nm = nack - base;
    endtask

    initial begin
        int lat, nm, base, acks0;
        bit seen;
        rst = 1'b1; ce = 1'b1; en = 1'b1; inv = 1'b0;
        bus.ia = '0; bus.ireq = 1'b0; bus.mid = '0; bus.miack = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        check("rst_iack", {31'b0, bus.iack}, 32'd0);
        check("rst_mireq", {31'b0, bus.mireq}, 32'd0);
        check("rst_mia", bus.mia, 32'd0);
        check("rst_id", bus.id, 32'd0);

        // Cold miss on the upper word of a line
        log_q.delete();
        fetch(32'h8000_0004, lat, nm);
        check("cold_macks", nm, 2);
        check("cold_mia0", log_q[0], 32'h8000_0000);
        check("cold_mia1", log_q[1], 32'h8000_0004);

        // Hit on the lower word: 2-cycle latency, no bus activity
        mireq_cyc = 0;
        fetch(32'h8000_0000, lat, nm);
        check("hit_lat", lat, 2);
        check("hit_macks", nm, 0);
        check("hit_mireq", mireq_cyc, 0);

        // Conflicting lines at the same index
        fetch(32'h8000_0400, lat, nm);
        check("conf_a_macks", nm, 2);
        fetch(32'h8000_0000, lat, nm);
        check("conf_b_macks", nm, 2);

        // Flush during FILL0: fill completes silently, line usable afterwards
        base = nack;
        acks0 = iack_cyc;
        bus.ia = 32'h8000_0808;
        bus.ireq = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.mireq) begin
                seen = 1;
                break;
            end
        end
        bus.ireq = 1'b0;
        check("flush_fill_started", {31'b0, seen}, 32'd1);
        repeat (15) cycle();
        check("flush_no_iack", iack_cyc - acks0, 0);
        check("flush_macks", nack - base, 2);
        fetch(32'h8000_080C, lat, nm);
        check("flush_refetch_macks", nm, 0);
        check("flush_refetch_lat", lat, 2);

        // INV pulse forces a refill
        inv = 1'b1;
        cycle();
        inv = 1'b0;
        fetch(32'h8000_0000, lat, nm);
        check("inv_macks", nm, 2);

        // INV coincident with the second fill ack: data returned, line left invalid
        inv_target = nack + 2;
        inv_arm = 1;
        fetch(32'h8000_0404, lat, nm);
        inv_arm = 0;
        inv = 1'b0;
        check("invfill_macks", nm, 2);
        fetch(32'h8000_0404, lat, nm);
        check("invfill_refetch_macks", nm, 2);

        // Pass-through mode; array must not be written
        en = 1'b0;
        log_q.delete();
        fetch(32'h8000_0002, lat, nm);
        check("byp_macks", nm, 1);
        check("byp_mia", log_q[0], 32'h8000_0000);
        fetch(32'h8000_0106, lat, nm);
        check("byp_mia_align", log_q[1], 32'h8000_0104);
        en = 1'b1;
        fetch(32'h8000_0400, lat, nm);
        check("byp_no_write_hit", nm, 0);

        // Reset while in FILL1
        base = nack;
        bus.ia = 32'h8000_1008;
        bus.ireq = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (nack == base + 1 && bus.mireq && !bus.miack) begin
                seen = 1;
                break;
            end
        end
        check("rstfill_in_fill1", {31'b0, seen}, 32'd1);
        rst = 1'b1;
        bus.ireq = 1'b0;
        cycle();
        check("rstfill_mireq", {31'b0, bus.mireq}, 32'd0);
        check("rstfill_iack", {31'b0, bus.iack}, 32'd0);
        rst = 1'b0;
        cycle();
        fetch(32'h8000_1008, lat, nm);
        check("rstfill_refetch_macks", nm, 2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
